// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: serialises instruction-fetch port A and data port B onto one memory interface
//  clk, rst_n                     clock, asynchronous active-low reset
//  mem_read_a/mem_address_a       port A read request (held until mem_resp_a)
//  mem_resp_a/mem_rdata_a         port A one-cycle completion and read data
//  mem_read_b/mem_write_b         port B request (held until mem_resp_b), write wins if both set
//  mem_wmask_b/mem_address_b/mem_wdata_b  port B command fields
//  mem_resp_b/mem_rdata_b         port B one-cycle completion and read data
//  pmem_read/pmem_write/pmem_wmask/pmem_address/pmem_wdata  registered downstream command
//  pmem_resp/pmem_rdata           downstream completion and read data
//  Build option ARB_ROUND_ROBIN_EN: alternate priority on contention instead of fixed B-over-A.
module mem_port_arbiter #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int MASK_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_read_a,
  input  logic [ADDR_W-1:0] mem_address_a,
  output logic              mem_resp_a,
  output logic [DATA_W-1:0] mem_rdata_a,
  input  logic              mem_read_b,
  input  logic              mem_write_b,
  input  logic [MASK_W-1:0] mem_wmask_b,
  input  logic [ADDR_W-1:0] mem_address_b,
  input  logic [DATA_W-1:0] mem_wdata_b,
  output logic              mem_resp_b,
  output logic [DATA_W-1:0] mem_rdata_b,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [MASK_W-1:0] pmem_wmask,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [DATA_W-1:0] pmem_wdata,
  input  logic              pmem_resp,
  input  logic [DATA_W-1:0] pmem_rdata
);
  typedef enum logic [1:0] {IDLE, SERVE_A, SERVE_B} state_t;
  state_t state, state_nx;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic [MASK_W-1:0] cmd_wmask;
  logic cmd_rd, cmd_wr;
  logic elig_a, elig_b, pick_b, open, done, grant_a, grant_b;
  assign done = (state != IDLE) & pmem_resp;
  assign open = (state == IDLE) | pmem_resp;
  // the port completing this edge still shows its held request; it must not win the same edge
  assign elig_a = mem_read_a & (state != SERVE_A);
  assign elig_b = (mem_read_b | mem_write_b) & (state != SERVE_B);
`ifdef ARB_ROUND_ROBIN_EN
  logic last_b;
  assign pick_b = elig_b & (~elig_a | ~last_b);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) last_b <= 1'b0;
    else if (grant_a | grant_b) last_b <= grant_b;
`else
  assign pick_b = elig_b;
`endif
  always_comb begin
    grant_b = 1'b0;
    grant_a = 1'b0;
    state_nx = state;
    grant_b = open & pick_b;
    grant_a = open & elig_a & ~pick_b;
    state_nx = grant_b ? SERVE_B : grant_a ? SERVE_A : done ? IDLE : state;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cmd_addr  <= '0;
      cmd_wdata <= '0;
      cmd_wmask <= '0;
      cmd_rd    <= 1'b0;
      cmd_wr    <= 1'b0;
    end else if (grant_b) begin
      cmd_addr  <= mem_address_b;
      cmd_wdata <= mem_write_b ? mem_wdata_b : '0;
      cmd_wmask <= mem_write_b ? mem_wmask_b : '1;
      cmd_rd    <= ~mem_write_b;
      cmd_wr    <= mem_write_b;
    end else if (grant_a) begin
      cmd_addr  <= mem_address_a;
      cmd_wdata <= '0;
      cmd_wmask <= '1;
      cmd_rd    <= 1'b1;
      cmd_wr    <= 1'b0;
    end else if (done) begin
      cmd_rd <= 1'b0;
      cmd_wr <= 1'b0;
    end
  assign pmem_read    = cmd_rd;
  assign pmem_write   = cmd_wr;
  assign pmem_wmask   = cmd_wmask;
  assign pmem_address = cmd_addr;
  assign pmem_wdata   = cmd_wdata;
  assign mem_resp_a   = (state == SERVE_A) & pmem_resp;
  assign mem_resp_b   = (state == SERVE_B) & pmem_resp;
  assign mem_rdata_a  = mem_resp_a ? pmem_rdata : '0;
  assign mem_rdata_b  = mem_resp_b ? pmem_rdata : '0;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed vector table, reset corner case and randomized model check for mem_port_arbiter
module tb_mem_port_arbiter;
`ifdef ARB_ROUND_ROBIN_EN
  localparam logic RR = 1'b1;
`else
  localparam logic RR = 1'b0;
`endif
  localparam logic T = 1'b1;
  localparam logic F = 1'b0;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic mem_read_a = 1'b0, mem_read_b = 1'b0, mem_write_b = 1'b0, pmem_resp = 1'b0;
  logic [15:0] mem_address_a = '0, mem_address_b = '0, mem_wdata_b = '0, pmem_rdata = '0;
  logic [1:0] mem_wmask_b = '0;
  logic mem_resp_a, mem_resp_b, pmem_read, pmem_write;
  logic [15:0] mem_rdata_a, mem_rdata_b, pmem_address, pmem_wdata;
  logic [1:0] pmem_wmask;
  int n_cmp = 0;
  int n_bad = 0;
  always #5 clk = ~clk;
  mem_port_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .mem_read_a(mem_read_a), .mem_address_a(mem_address_a),
    .mem_resp_a(mem_resp_a), .mem_rdata_a(mem_rdata_a),
    .mem_read_b(mem_read_b), .mem_write_b(mem_write_b), .mem_wmask_b(mem_wmask_b),
    .mem_address_b(mem_address_b), .mem_wdata_b(mem_wdata_b),
    .mem_resp_b(mem_resp_b), .mem_rdata_b(mem_rdata_b),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_wmask(pmem_wmask),
    .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
    .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata)
  );
  typedef struct {
    logic ra, rb, wb;
    logic [1:0] wm;
    logic [15:0] aa, ab, wd;
    logic pr;
    logic [15:0] prd;
    logic erd, ewr;
    logic [15:0] ea;
    logic [1:0] ewm;
    logic [15:0] ewd;
    logic era, erb;
  } vec_t;
  vec_t tbl[$];
  function automatic vec_t mk(input logic ra, rb, wb, input logic [1:0] wm,
                              input logic [15:0] aa, ab, wd, input logic pr, input logic [15:0] prd,
                              input logic erd, ewr, input logic [15:0] ea, input logic [1:0] ewm,
                              input logic [15:0] ewd, input logic era, erb);
    vec_t v;
    v.ra = ra; v.rb = rb; v.wb = wb; v.wm = wm; v.aa = aa; v.ab = ab; v.wd = wd;
    v.pr = pr; v.prd = prd; v.erd = erd; v.ewr = ewr; v.ea = ea; v.ewm = ewm;
    v.ewd = ewd; v.era = era; v.erb = erb;
    return v;
  endfunction
  function automatic vec_t idle(input logic ra, rb, wb, input logic [1:0] wm,
                                input logic [15:0] aa, ab, wd);
    return mk(ra, rb, wb, wm, aa, ab, wd, F, 16'h0, F, F, 16'h0, 2'd0, 16'h0, F, F);
  endfunction
  task automatic chk1(input string nm, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %b expected %b", nm, $time, act, exp);
    end
  endtask
  task automatic chk16(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask
  int busy;
  logic m_rd, m_wr, last_b, ea, eb, pb, e_ra, e_rb;
  logic [15:0] m_addr, m_wd;
  logic [1:0] m_wm;
  initial begin
    pmem_resp = 1'b1;
    pmem_rdata = 16'hFFFF;
    repeat (2) @(negedge clk);
    chk1("rst_pmem_read", pmem_read, F);
    chk1("rst_pmem_write", pmem_write, F);
    chk16("rst_pmem_wmask", {14'd0, pmem_wmask}, 16'h0);
    chk16("rst_pmem_address", pmem_address, 16'h0);
    chk16("rst_pmem_wdata", pmem_wdata, 16'h0);
    chk1("rst_resp_a", mem_resp_a, F);
    chk1("rst_resp_b", mem_resp_b, F);
    chk16("rst_rdata_a", mem_rdata_a, 16'h0);
    chk16("rst_rdata_b", mem_rdata_b, 16'h0);
    pmem_resp = 1'b0;
    rst_n = 1'b1;
    // A-only read, latency 3
    tbl.push_back(idle(T, F, F, 2'd0, 16'h1000, 16'h0, 16'h0));
    tbl.push_back(mk(T, F, F, 2'd0, 16'h1000, 16'h0, 16'h0, F, 16'h0, T, F, 16'h1000, 2'd3, 16'h0, F, F));
    tbl.push_back(mk(T, F, F, 2'd0, 16'h1000, 16'h0, 16'h0, F, 16'h0, T, F, 16'h1000, 2'd3, 16'h0, F, F));
    tbl.push_back(mk(T, F, F, 2'd0, 16'h1000, 16'h0, 16'h0, T, 16'hBEEF, T, F, 16'h1000, 2'd3, 16'h0, T, F));
    tbl.push_back(idle(F, F, F, 2'd0, 16'h0, 16'h0, 16'h0));
    // B write
    tbl.push_back(idle(F, F, T, 2'd1, 16'h0, 16'h2002, 16'h1234));
    tbl.push_back(mk(F, F, T, 2'd1, 16'h0, 16'h2002, 16'h1234, F, 16'h0, F, T, 16'h2002, 2'd1, 16'h1234, F, F));
    tbl.push_back(mk(F, F, T, 2'd1, 16'h0, 16'h2002, 16'h1234, T, 16'h5555, F, T, 16'h2002, 2'd1, 16'h1234, F, T));
    tbl.push_back(idle(F, F, F, 2'd0, 16'h0, 16'h0, 16'h0));
    // contention: B first, then A with no idle cycle
    tbl.push_back(idle(T, T, F, 2'd0, 16'h0010, 16'h3000, 16'h0));
    tbl.push_back(mk(T, T, F, 2'd0, 16'h0010, 16'h3000, 16'h0, T, 16'hAAAA, T, F, 16'h3000, 2'd3, 16'h0, F, T));
    tbl.push_back(mk(T, F, F, 2'd0, 16'h0010, 16'h0, 16'h0, T, 16'h1111, T, F, 16'h0010, 2'd3, 16'h0, T, F));
    // B alone, then a second contention (alternates under round robin)
    tbl.push_back(idle(F, T, F, 2'd0, 16'h0, 16'h3002, 16'h0));
    tbl.push_back(mk(F, T, F, 2'd0, 16'h0, 16'h3002, 16'h0, T, 16'h0BAD, T, F, 16'h3002, 2'd3, 16'h0, F, T));
    tbl.push_back(idle(T, T, F, 2'd0, 16'h0020, 16'h3004, 16'h0));
    tbl.push_back(mk(T, T, F, 2'd0, 16'h0020, 16'h3004, 16'h0, T, 16'h2222, T, F,
                     RR ? 16'h0020 : 16'h3004, 2'd3, 16'h0, RR, ~RR));
    tbl.push_back(mk(F, F, F, 2'd0, 16'h0020, 16'h3004, 16'h0, T, 16'h3333, T, F,
                     RR ? 16'h3004 : 16'h0020, 2'd3, 16'h0, ~RR, RR));
    tbl.push_back(idle(F, F, F, 2'd0, 16'h0, 16'h0, 16'h0));
    // read and write together: write wins
    tbl.push_back(idle(F, T, T, 2'd2, 16'h0, 16'h4000, 16'h9999));
    tbl.push_back(mk(F, T, T, 2'd2, 16'h0, 16'h4000, 16'h9999, T, 16'h0, F, T, 16'h4000, 2'd2, 16'h9999, F, T));
    tbl.push_back(idle(F, F, F, 2'd0, 16'h0, 16'h0, 16'h0));
    // address change during SERVE_A
    tbl.push_back(idle(T, F, F, 2'd0, 16'h0100, 16'h0, 16'h0));
    tbl.push_back(mk(T, F, F, 2'd0, 16'h0200, 16'h0, 16'h0, F, 16'h0, T, F, 16'h0100, 2'd3, 16'h0, F, F));
    tbl.push_back(mk(T, F, F, 2'd0, 16'h0200, 16'h0, 16'h0, T, 16'h4444, T, F, 16'h0100, 2'd3, 16'h0, T, F));
    tbl.push_back(idle(F, F, F, 2'd0, 16'h0, 16'h0, 16'h0));
    @(posedge clk);
    #1;
    foreach (tbl[i]) begin
      mem_read_a = tbl[i].ra; mem_read_b = tbl[i].rb; mem_write_b = tbl[i].wb;
      mem_wmask_b = tbl[i].wm; mem_address_a = tbl[i].aa; mem_address_b = tbl[i].ab;
      mem_wdata_b = tbl[i].wd; pmem_resp = tbl[i].pr; pmem_rdata = tbl[i].prd;
      @(negedge clk);
      chk1($sformatf("vec%0d_pmem_read", i), pmem_read, tbl[i].erd);
      chk1($sformatf("vec%0d_pmem_write", i), pmem_write, tbl[i].ewr);
      if (tbl[i].erd | tbl[i].ewr) begin
        chk16($sformatf("vec%0d_pmem_address", i), pmem_address, tbl[i].ea);
        chk16($sformatf("vec%0d_pmem_wmask", i), {14'd0, pmem_wmask}, {14'd0, tbl[i].ewm});
      end
      if (tbl[i].ewr) chk16($sformatf("vec%0d_pmem_wdata", i), pmem_wdata, tbl[i].ewd);
      chk1($sformatf("vec%0d_resp_a", i), mem_resp_a, tbl[i].era);
      chk1($sformatf("vec%0d_resp_b", i), mem_resp_b, tbl[i].erb);
      chk16($sformatf("vec%0d_rdata_a", i), mem_rdata_a, tbl[i].era ? tbl[i].prd : 16'h0);
      chk16($sformatf("vec%0d_rdata_b", i), mem_rdata_b, tbl[i].erb ? tbl[i].prd : 16'h0);
      @(posedge clk);
      #1;
    end
    // reset asserted mid SERVE_B
    mem_read_b = 1'b1; mem_address_b = 16'h5000;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk1("rstmid_pmem_read_before", pmem_read, T);
    chk16("rstmid_addr_before", pmem_address, 16'h5000);
    #2;
    rst_n = 1'b0;
    pmem_resp = 1'b1;
    #1;
    chk1("rstmid_pmem_read", pmem_read, F);
    chk1("rstmid_pmem_write", pmem_write, F);
    chk1("rstmid_resp_b", mem_resp_b, F);
    mem_read_b = 1'b0;
    pmem_resp = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    mem_read_a = 1'b1; mem_address_a = 16'h6000;
    @(negedge clk);
    chk1("rstmid_idle_after", pmem_read, F);
    @(negedge clk);
    chk1("rstmid_a_granted", pmem_read, T);
    chk16("rstmid_a_addr", pmem_address, 16'h6000);
    pmem_resp = 1'b1; pmem_rdata = 16'h7777;
    #1;
    chk1("rstmid_a_resp", mem_resp_a, T);
    chk16("rstmid_a_rdata", mem_rdata_a, 16'h7777);
    chk1("rstmid_b_quiet", mem_resp_b, F);
    @(posedge clk);
    #1;
    mem_read_a = 1'b0; pmem_resp = 1'b0;
    @(negedge clk);
    chk1("rstmid_a_done", pmem_read, F);
    // randomized phase against a transaction-level model
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    busy = 0; m_rd = 1'b0; m_wr = 1'b0; last_b = 1'b0;
    m_addr = '0; m_wd = '0; m_wm = '0;
    @(posedge clk);
    #1;
    for (int c = 0; c < 3000; c++) begin
      mem_read_a = ($urandom % 2) == 0;
      mem_read_b = ($urandom % 3) == 0;
      mem_write_b = ($urandom % 4) == 0;
      mem_wmask_b = 2'($urandom);
      mem_address_a = 16'($urandom);
      mem_address_b = 16'($urandom);
      mem_wdata_b = 16'($urandom);
      pmem_resp = (busy != 0) && (($urandom % 3) == 0);
      pmem_rdata = 16'($urandom);
      @(negedge clk);
      e_ra = (busy == 1) && pmem_resp;
      e_rb = (busy == 2) && pmem_resp;
      chk1("rnd_pmem_read", pmem_read, m_rd);
      chk1("rnd_pmem_write", pmem_write, m_wr);
      if (m_rd | m_wr) begin
        chk16("rnd_pmem_address", pmem_address, m_addr);
        chk16("rnd_pmem_wmask", {14'd0, pmem_wmask}, {14'd0, m_wm});
      end
      if (m_wr) chk16("rnd_pmem_wdata", pmem_wdata, m_wd);
      chk1("rnd_resp_a", mem_resp_a, e_ra);
      chk1("rnd_resp_b", mem_resp_b, e_rb);
      chk16("rnd_rdata_a", mem_rdata_a, e_ra ? pmem_rdata : 16'h0);
      chk16("rnd_rdata_b", mem_rdata_b, e_rb ? pmem_rdata : 16'h0);
      if (busy == 0 || pmem_resp) begin
        ea = mem_read_a && busy != 1;
        eb = (mem_read_b || mem_write_b) && busy != 2;
        pb = eb && (!ea || !RR || !last_b);
        if (pb) begin
          busy = 2; m_wr = mem_write_b; m_rd = !mem_write_b; m_addr = mem_address_b;
          m_wm = mem_write_b ? mem_wmask_b : 2'd3; m_wd = mem_wdata_b; last_b = 1'b1;
        end else if (ea) begin
          busy = 1; m_wr = 1'b0; m_rd = 1'b1; m_addr = mem_address_a; m_wm = 2'd3; last_b = 1'b0;
        end else begin
          busy = 0; m_wr = 1'b0; m_rd = 1'b0;
        end
      end
      @(posedge clk);
      #1;
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
